// File: rtl/spi_byte_shifter.sv
// Mode-0 SPI master byte engine: shifts one byte out on MOSI and one in from MISO per execute pulse.
// Optional SPI_SHIFTER_MISO_SYNC_EN inserts a 2-flop MISO synchronizer (dividers must then be >= 3).
module spi_byte_shifter #(
    parameter int SLOW_DIV = 63,
    parameter int FAST_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       execute,
    input  logic       fast,
    input  logic [7:0] out_word,
    input  logic       miso,
    output logic       spi_clk,
    output logic       mosi,
    output logic [7:0] in_word,
    output logic       finished,
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

    localparam logic [7:0] LP_SLOW = 8'(SLOW_DIV);
    localparam logic [7:0] LP_FAST = 8'(FAST_DIV);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic [7:0] r_div;
    logic [7:0] r_tx;
    logic [7:0] r_rx;
    logic [2:0] r_bit;
    logic       w_miso;
    logic       w_last;

`ifdef SPI_SHIFTER_MISO_SYNC_EN
    logic [1:0] r_sync;

    if (FAST_DIV < 3 || SLOW_DIV < 3) begin : g_div_chk
        $error("spi_byte_shifter: dividers must be >= 3 with the MISO synchronizer");
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 2'b11;
        else        r_sync <= {r_sync[0], miso};
    end
    assign w_miso = r_sync[1];
`else
    assign w_miso = miso;
`endif

    // Half-period expires when the counter reaches D-1
    assign w_last = (r_cnt == r_div - 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_div    <= 8'd1;
            r_tx     <= 8'd0;
            r_rx     <= 8'd0;
            r_bit    <= 3'd0;
            spi_clk  <= 1'b0;
            mosi     <= 1'b1;
            in_word  <= 8'h00;
            finished <= 1'b0;
            busy     <= 1'b0;
        end else begin
            finished <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (execute) begin
                        r_tx    <= out_word;
                        mosi    <= out_word[7];
                        r_div   <= fast ? LP_FAST : LP_SLOW;
                        r_cnt   <= 8'd0;
                        r_bit   <= 3'd0;
                        busy    <= 1'b1;
                        r_state <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (w_last) begin
                        r_cnt   <= 8'd0;
                        spi_clk <= 1'b1;
                        r_rx    <= {r_rx[6:0], w_miso};
                        r_state <= S_HIGH;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_HIGH: begin
                    if (w_last) begin
                        r_cnt   <= 8'd0;
                        spi_clk <= 1'b0;
                        if (r_bit != 3'd7) begin
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= {r_tx[6:0], 1'b0};
                            mosi    <= r_tx[6];
                            r_state <= S_LOW;
                        end else begin
                            in_word  <= r_rx;
                            finished <= 1'b1;
                            busy     <= 1'b0;
                            mosi     <= 1'b1;
                            r_state  <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Directed bench for spi_byte_shifter with a mode-0 slave model and SCLK/MOSI/finished monitors.
`timescale 1ns/1ps
module tb_spi_byte_shifter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       execute = 1'b0;
    logic       fast = 1'b0;
    logic [7:0] out_word = 8'h00;
    logic       miso;
    logic       spi_clk, mosi, finished, busy;
    logic [7:0] in_word;

    spi_byte_shifter #(.SLOW_DIV(63), .FAST_DIV(3)) dut (
        .clk(clk), .rst_n(rst_n), .execute(execute), .fast(fast),
        .out_word(out_word), .miso(miso), .spi_clk(spi_clk), .mosi(mosi),
        .in_word(in_word), .finished(finished), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled mid-cycle; cyc equals the index of the preceding rising edge
    int   n_rise = 0, n_fall = 0, fin_cnt = 0, fin_t = 0, busy_cnt = 0;
    int   rise_t [256];
    logic rise_m [256];
    logic prev_sclk = 1'b0;
    always @(negedge clk) begin
        if (spi_clk && !prev_sclk) begin
            rise_t[n_rise % 256] = cyc;
            rise_m[n_rise % 256] = mosi;
            n_rise = n_rise + 1;
        end
        if (!spi_clk && prev_sclk) n_fall = n_fall + 1;
        if (finished) begin
            fin_cnt = fin_cnt + 1;
            fin_t   = cyc;
        end
        if (busy) busy_cnt = busy_cnt + 1;
        prev_sclk = spi_clk;
    end

    // Slave: presents MSB first, advances after each SCLK fall
    logic [7:0] s_byte = 8'hFF;
    int         s_base = 0;
    int         s_idx;
    assign s_idx = n_fall - s_base;
    always_comb miso = (s_idx >= 0 && s_idx < 8) ? s_byte[3'(7 - s_idx)] : 1'b1;

    int errs = 0, checks = 0;
    int e0, r0, f0, b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] ob, input logic f, input logic [7:0] sb);
        out_word = ob;
        fast     = f;
        s_byte   = sb;
        s_base   = n_fall;
        r0       = n_rise;
        f0       = fin_cnt;
        b0       = busy_cnt;
        e0       = cyc + 1;
        execute  = 1'b1;
        tick();
        execute  = 1'b0;
    endtask

    task automatic wait_fin(input string tag, input int maxc);
        int n = 0;
        while (fin_cnt == f0 && n < maxc) begin
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(fin_cnt != f0), 32'd1);
    endtask

    task automatic check_xfer(input string tag, input logic [7:0] tx, input logic [7:0] rx, input int d);
        logic [7:0] wire_b;
        for (int i = 0; i < 8; i++) wire_b[7-i] = rise_m[(r0 + i) % 256];
        check({tag, "_in_word"}, 32'(in_word), 32'(rx));
        check({tag, "_mosi"}, 32'(wire_b), 32'(tx));
        check({tag, "_nrise"}, 32'(n_rise - r0), 32'd8);
        check({tag, "_rise0"}, 32'(rise_t[r0 % 256] - e0), 32'(d));
        check({tag, "_rise7"}, 32'(rise_t[(r0 + 7) % 256] - e0), 32'(15 * d));
        check({tag, "_fin_t"}, 32'(fin_t - e0), 32'(16 * d));
        check({tag, "_busy"}, 32'(busy_cnt - b0), 32'(16 * d));
        check({tag, "_busy_lo"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic bad;
        int   n;

        // Reset and idle
        repeat (3) tick();
        check("rst_sclk", 32'(spi_clk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (100) begin
            tick();
            if (spi_clk !== 1'b0 || mosi !== 1'b1 || in_word !== 8'h00 ||
                finished !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        check("idle_stable", 32'(bad), 32'd0);
        check("idle_in_word", 32'(in_word), 32'h00);

        // Fast byte
        start(8'hA5, 1'b1, 8'h3C);
        wait_fin("fastA5", 200);
        check_xfer("fastA5", 8'hA5, 8'h3C, 3);
        check("fastA5_fincnt", 32'(fin_cnt - f0), 32'd1);
        repeat (3) tick();
        check("fastA5_hold", 32'(in_word), 32'h3C);

        // Ignored execute mid-transfer, then back-to-back
        start(8'h96, 1'b1, 8'h5A);
        while (cyc < e0 + 9) tick();
        execute  = 1'b1;
        out_word = 8'h00;
        fast     = 1'b0;
        tick();
        execute  = 1'b0;
        wait_fin("hs", 200);
        check_xfer("hs", 8'h96, 8'h5A, 3);
        check("hs_fincnt", 32'(fin_cnt - f0), 32'd1);
        start(8'hC3, 1'b1, 8'h81);
        wait_fin("b2b", 200);
        check_xfer("b2b", 8'hC3, 8'h81, 3);

        // Slow byte with fast toggled mid-transfer
        start(8'hFF, 1'b0, 8'h01);
        while (cyc < e0 + 9) tick();
        fast = 1'b1;
        wait_fin("slow", 1200);
        check_xfer("slow", 8'hFF, 8'h01, 63);
        check("slow_period", 32'(rise_t[(r0 + 1) % 256] - rise_t[r0 % 256]), 32'd126);
        start(8'h00, 1'b1, 8'hFF);
        wait_fin("after_slow", 200);
        check_xfer("after_slow", 8'h00, 8'hFF, 3);

        // Reset mid-transfer
        start(8'h0F, 1'b1, 8'hAA);
        n = 0;
        while (n_rise - r0 < 4 && n < 200) begin
            tick();
            n++;
        end
        check("abort_reach4", 32'(n_rise - r0), 32'd4);
        tick();
        rst_n = 1'b0;
        #1;
        check("abort_sclk", 32'(spi_clk), 32'd0);
        check("abort_mosi", 32'(mosi), 32'd1);
        check("abort_in_word", 32'(in_word), 32'h00);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_fin", 32'(finished), 32'd0);
        repeat (3) tick();
        check("abort_nofin", 32'(fin_cnt - f0), 32'd0);
        rst_n = 1'b1;
        tick();
        start(8'h5A, 1'b1, 8'hC3);
        wait_fin("post_abort", 200);
        check_xfer("post_abort", 8'h5A, 8'hC3, 3);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/spi_byte_shifter.md
# spi_byte_shifter

Mode-0 SPI master byte engine that sits directly below the SD card command/read sequencer. The sequencer hands it one byte and a one-cycle start pulse. The block shifts that byte out on MOSI while shifting one byte in from MISO, then returns the received byte with a one-cycle completion pulse. A per-transfer speed select covers the slow (≤400 kHz) card-init rate and the fast data rate.

## Interface
- `SLOW_DIV`, default 63: SCLK half-period in clk cycles when `fast`=0; legal range 1–255.
- `FAST_DIV`, default 2: SCLK half-period in clk cycles when `fast`=1; legal range 1–255.
- `clk` input 1: master clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `execute` input 1: one-cycle start pulse; sampled only in IDLE.
- `fast` input 1: divider select (1 = `FAST_DIV`, 0 = `SLOW_DIV`); latched at start.
- `out_word` input 8: byte to transmit, MSB first; latched at start.
- `miso` input 1: serial data from card.
- `spi_clk` output 1: SCLK; idles low.
- `mosi` output 1: serial data to card; idles high.
- `in_word` output 8: last received byte; held until the next completion.
- `finished` output 1: one-cycle pulse when `in_word` updates.
- `busy` output 1: high while a transfer is in progress.

## Operation
- States:
  - IDLE: `spi_clk`=0, `mosi`=1.
  - LOW: SCLK low phase; MOSI holds the current bit.
  - HIGH: SCLK high phase.
- IDLE→LOW when `execute`=1 at the edge:
  - Shift register ← `out_word`; `mosi` ← `out_word[7]`.
  - D ← `fast` ? `FAST_DIV` : `SLOW_DIV`.
  - Half-period counter ← 0, bit counter ← 0, `busy` ← 1.
- LOW→HIGH after D cycles in LOW:
  - `spi_clk` ← 1.
  - Sample `miso` (or the synchronized `miso`) into rx shift register LSB, shifting left.
- HIGH after D cycles:
  - `spi_clk` ← 0.
  - If bit counter < 7: increment bit counter; `mosi` ← next bit; go to LOW.
  - If bit counter = 7: `in_word` ← rx shift register; `finished` ← 1 for one cycle; `busy` ← 0; `mosi` ← 1; go to IDLE.
- Ignored inputs:
  - `execute` while `busy`=1 is ignored.
  - `fast` and `out_word` changes mid-transfer have no effect.
- Counters:
  - Half-period counter is 8 bits; it compares against D−1, then clears.
  - Bit counter is 3 bits.
- Reset:
  - `rst_n` low at any time, including mid-transfer, immediately forces IDLE and all outputs to reset values.
  - No `finished` pulse is generated for an aborted transfer.

## Timing
- Reset values: `spi_clk`=0, `mosi`=1, `in_word`=8'h00, `finished`=0, `busy`=0.
- Edge E0 samples `execute`:
  - `busy` is high from E0 through E0+16D−1.
  - `finished` is high for exactly the cycle after edge E0+16D.
  - `busy` is low in that same cycle.
- SCLK:
  - Rising edges occur at E0+D, E0+3D, …, E0+15D.
  - Period is 2D cycles; duty is 50%.
- MOSI changes only when `spi_clk` falls, or at E0, giving D cycles of setup before each rising edge.
- Back-to-back: `execute` sampled at edge E0+16D+1, the cycle `finished` is high, starts the next transfer. This gives a minimum gap of one clk cycle of SCLK low.
- `execute` and completion coinciding at edge E0+16D: `execute` is ignored because state is still HIGH at that edge.

## Configuration
- `SPI_SHIFTER_MISO_SYNC_EN`:
  - Defined: `miso` passes through a 2-flop synchronizer before sampling, so the sampled value is `miso` as seen 2 cycles before the SCLK rising edge. `FAST_DIV` and `SLOW_DIV` must each be ≥3; elaboration errors otherwise.
  - Undefined: raw `miso` is sampled at the SCLK-rising edge. Divider minimum is 1.
- Neither setting changes SCLK or MOSI timing.

## Test plan
- Reset/idle: hold `rst_n`=0 then release with no `execute`. Outputs must be `spi_clk`=0, `mosi`=1, `in_word`=00, `finished`=0, `busy`=0, stable for 100 cycles.
- Fast byte, `FAST_DIV`=3, `fast`=1, `out_word`=A5, slave model returns 3C:
  - MOSI at the 8 SCLK rises is 1,0,1,0,0,1,0,1.
  - `busy` stays high 48 cycles; `finished` pulses once, 48 cycles after E0.
  - `in_word`=3C.
- Slow byte, `SLOW_DIV`=63, `fast`=0, `out_word`=FF, slave returns 01: SCLK period is 126 cycles; `finished` comes at E0+1008; `in_word`=01.
- Handshake:
  - `execute` pulsed at E0+10 mid-transfer is ignored: exactly one `finished`, and `out_word` is unchanged on the wire.
  - `execute` in the `finished` cycle starts the second byte immediately; its first SCLK rise is at E0+16D+1+D.
- Reset mid-transfer: assert `rst_n` low after the 4th SCLK rise. Outputs return to reset values asynchronously with no `finished`. A following transfer of 5A/C3 completes correctly.
- `fast` toggled 0→1 mid-transfer: period stays 2·`SLOW_DIV`; the next transfer uses `FAST_DIV`.
